// File: rtl/sad_search_scheduler_if.sv
// Handshake bundle between the SAD search scheduler and the MEM/result pipeline.
interface sad_search_scheduler_if;
   logic        start;
   logic        stall;
   logic        result_valid;
   logic        result_trigger_boss;
   logic        issue_valid;
   logic [15:0] issue_index;
   logic        issue_trigger_boss;
   logic        busy;
   logic        done;
   logic [7:0]  in_flight;

   // Controller / pipeline side that drives the requests and observes the issues.
   modport master (
      output start, stall, result_valid, result_trigger_boss,
      input  issue_valid, issue_index, issue_trigger_boss, busy, done, in_flight
   );

   // Scheduler side.
   modport slave (
      input  start, stall, result_valid, result_trigger_boss,
      output issue_valid, issue_index, issue_trigger_boss, busy, done, in_flight
   );
endinterface

// File: rtl/sad_search_scheduler.sv
// SAD motion-search scheduler: walks the candidate grid, issues one base index
// per unstalled cycle, tags the last candidate and waits for it to retire.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | waiting for start; counters parked
//   S_RUN   | issuing candidates, one per unstalled cycle
//   S_DRAIN | all issued; waiting for the tagged result to retire
//   S_DONE  | one-cycle completion pulse, then back to S_IDLE
module sad_search_scheduler #(
   parameter int FRAME_W = 64,
   parameter int FRAME_H = 64,
   parameter int STEP    = 4,
   parameter int SPAN    = 7
) (
   input  logic                   clk,
   input  logic                   reset,
   sad_search_scheduler_if.slave  bus
);

   localparam logic [15:0] X_MAX    = 16'(((FRAME_W - SPAN) / STEP) * STEP);
   localparam logic [15:0] Y_MAX    = 16'(((FRAME_H - SPAN) / STEP) * STEP);
   localparam logic [15:0] STEP16   = 16'(STEP);
   localparam logic [15:0] ROW_STEP = 16'(STEP * FRAME_W);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t      state_q;
   logic [15:0] x_q;
   logic [15:0] y_q;
   logic [15:0] index_q;
   logic [7:0]  in_flight_q;
   logic [7:0]  in_flight_d;

   logic issue;
   logic last;
   logic retire;

   // A cycle with reset asserted never counts as an issue, so nothing leaks
   // into MEM on the edge that aborts a search.
   assign issue  = (state_q == S_RUN) && !bus.stall && !reset;
   assign last   = (x_q == X_MAX) && (y_q == Y_MAX);
   assign retire = bus.result_valid && (in_flight_q != 8'd0);

   // Outstanding-candidate count: floor at zero, saturate at the top.
   always_comb begin
      in_flight_d = in_flight_q;
      case ({issue, retire})
         2'b10:   in_flight_d = (in_flight_q == 8'hFF) ? in_flight_q : in_flight_q + 8'd1;
         2'b01:   in_flight_d = in_flight_q - 8'd1;
         default: in_flight_d = in_flight_q;
      endcase
   end

   // Sequencer: state, raster counters and the linear index that tracks them.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         x_q         <= 16'd0;
         y_q         <= 16'd0;
         index_q     <= 16'd0;
         in_flight_q <= 8'd0;
      end else begin
         in_flight_q <= in_flight_d;
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  state_q     <= S_RUN;
                  x_q         <= 16'd0;
                  y_q         <= 16'd0;
                  index_q     <= 16'd0;
                  in_flight_q <= 8'd0;
               end
            end
            S_RUN: begin
               if (issue) begin
                  if (x_q != X_MAX) begin
                     x_q     <= x_q + STEP16;
                     index_q <= index_q + STEP16;
                  end else if (y_q != Y_MAX) begin
                     // Row wrap: drop back by the row width walked, advance STEP rows.
                     x_q     <= 16'd0;
                     y_q     <= y_q + STEP16;
                     index_q <= index_q - X_MAX + ROW_STEP;
                  end else begin
                     state_q <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (bus.result_valid && bus.result_trigger_boss) state_q <= S_DONE;
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.issue_valid        = issue;
   assign bus.issue_index        = index_q;
   assign bus.issue_trigger_boss = issue && last;
   assign bus.busy               = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign bus.done               = (state_q == S_DONE);
   assign bus.in_flight          = in_flight_q;

endmodule

// File: tb/tb_sad_search_scheduler.sv
// Directed bench for sad_search_scheduler: full scan, stall hold, drain timing,
// retire bookkeeping and abort/restart, with a 6-deep model result pipeline.
module tb_sad_search_scheduler;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sad_search_scheduler_if bus ();

   sad_search_scheduler dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Observed outputs of the most recent cycle.
   logic        o_iv, o_tb, o_busy, o_done;
   logic [15:0] o_idx;
   logic [7:0]  o_if;
   logic        rv_seen;       // tagged result presented in that cycle
   int          e_if = 0;      // expected in_flight for that cycle
   int          m_if = 0;      // model of outstanding issues
   int          peak = 0;
   logic        rv_force = 1'b0;
   logic [1:0]  pipe [6];      // {valid, tag}, result returns 6 cycles after issue

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_idx(input int k);
      return 32'((k % 15) * 4 + (k / 15) * 256);
   endfunction

   // One clock cycle: called at the falling edge with start/stall/reset set.
   task automatic cycle();
      bus.result_valid        = pipe[5][1] | rv_force;
      bus.result_trigger_boss = pipe[5][0] & ~rv_force;
      #1;
      o_iv    = bus.issue_valid;
      o_idx   = bus.issue_index;
      o_tb    = bus.issue_trigger_boss;
      o_busy  = bus.busy;
      o_done  = bus.done;
      o_if    = bus.in_flight;
      rv_seen = bus.result_valid && bus.result_trigger_boss;
      e_if    = m_if;
      if (reset) m_if = 0;
      else if (bus.start && !o_busy && !o_done) m_if = 0;
      else begin
         if (o_iv && !(bus.result_valid && m_if != 0)) m_if = (m_if == 255) ? 255 : m_if + 1;
         else if (!o_iv && bus.result_valid && m_if != 0) m_if = m_if - 1;
      end
      for (int i = 5; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = {o_iv, o_tb};
      if (reset) for (int i = 0; i < 6; i++) pipe[i] = 2'b00;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Issues k = first..last; optional stall burst before stall_k, start pulse at start_k.
   task automatic run_issues(input int first, input int last, input int stall_k,
                             input int nstall, input int start_k);
      for (int k = first; k <= last; k++) begin
         if (k == stall_k) begin
            for (int s = 0; s < nstall; s++) begin
               bus.stall = 1'b1;
               cycle();
               chk("stall_iv", o_iv, 0);
               chk("stall_idx", o_idx, exp_idx(k));
               chk("stall_tb", o_tb, 0);
            end
            bus.stall = 1'b0;
         end
         bus.start = (k == start_k);
         cycle();
         bus.start = 1'b0;
         chk("issue_iv", o_iv, 1);
         chk("issue_idx", o_idx, exp_idx(k));
         chk("issue_tb", o_tb, (k == 224) ? 1 : 0);
         chk("issue_busy", o_busy, 1);
         chk("issue_in_flight", o_if, 32'(e_if));
         if (int'(o_if) > peak) peak = int'(o_if);
      end
   endtask

   // After the final issue: tagged result 6 cycles later, done one cycle after that.
   task automatic drain();
      int   tag_at  = -1;
      int   done_at = -1;
      int   ndone   = 0;
      logic busy_tag  = 1'b0;
      logic busy_done = 1'b1;
      logic [7:0] if_done = 8'hFF;
      for (int i = 0; i < 12; i++) begin
         cycle();
         chk("drain_iv", o_iv, 0);
         if (o_done) begin
            ndone++;
            if (done_at < 0) begin
               done_at   = i;
               busy_done = o_busy;
               if_done   = o_if;
            end
         end
         if (rv_seen && tag_at < 0) begin
            tag_at   = i;
            busy_tag = o_busy;
         end
      end
      chk("tag_cycle", 32'(tag_at), 5);
      chk("done_cycle", 32'(done_at), 6);
      chk("done_pulses", 32'(ndone), 1);
      chk("busy_at_tag", busy_tag, 1);
      chk("busy_at_done", busy_done, 0);
      chk("in_flight_at_done", if_done, 0);
   endtask

   initial begin
      for (int i = 0; i < 6; i++) pipe[i] = 2'b00;
      bus.stall = 1'b0;
      bus.result_valid = 1'b0;
      bus.result_trigger_boss = 1'b0;

      // Reset held two cycles with start high.
      reset = 1'b1;
      bus.start = 1'b1;
      cycle();
      cycle();
      chk("rst_iv", o_iv, 0);
      chk("rst_idx", o_idx, 0);
      chk("rst_tb", o_tb, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_in_flight", o_if, 0);
      reset = 1'b0;
      bus.start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("idle_busy", o_busy, 0);
         chk("idle_iv", o_iv, 0);
      end

      // Full unstalled scan followed by drain.
      bus.start = 1'b1;
      cycle();
      bus.start = 1'b0;
      chk("start_cycle_iv", o_iv, 0);
      peak = 0;
      run_issues(0, 224, -1, 0, -1);
      chk("in_flight_peak", 32'(peak), 6);
      drain();

      // Retire with nothing outstanding must not wrap the counter.
      rv_force = 1'b1;
      cycle();
      rv_force = 1'b0;
      cycle();
      chk("retire_at_zero", o_if, 0);
      chk("retire_at_zero_busy", o_busy, 0);

      // Abort at issue 100 with reset; no completion afterwards.
      bus.start = 1'b1;
      cycle();
      bus.start = 1'b0;
      run_issues(0, 99, -1, 0, -1);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         chk("abort_done", o_done, 0);
         chk("abort_busy", o_busy, 0);
         chk("abort_iv", o_iv, 0);
      end
      chk("abort_in_flight", o_if, 0);

      // Restart from index 0; 3-cycle stall at index 308; stray start mid-run.
      bus.start = 1'b1;
      cycle();
      bus.start = 1'b0;
      run_issues(0, 224, 28, 3, 50);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
